ws2812_rx_decoder: RTL

Receive-side counterpart of the LED stripe transmitter. Samples a single-wire WS2812 NRZ stream, classifies each high pulse as a 0 or 1 bit by its width, assembles 24-bit GRB pixels, and detects the low "reset/latch" gap that ends a frame. It is used as a loop-back checker on the transmitter's `led_stripe_pin` and as the input stage of a future daisy-chain repeater.

---
 rtl/ws2812_pkg.sv | 17 +
 rtl/ws2812_rx_decoder_pin_sync_edge.sv | 40 ++++
 rtl/ws2812_rx_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Constants shared between the WS2812 transmitter and the receive decoder,
// plus the decoder state encodings.
package ws2812_pkg;

   localparam int T0H          = 10;
   localparam int T1H          = 20;
   localparam int BIT_PERIOD   = 31;
   localparam int RESET_CYCLES = 1250;
   localparam int PIXEL_W      = 24;

   typedef logic [PIXEL_W-1:0] pixel_t;

   localparam logic [1:0] ST_LOW  = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

// File: rtl/ws2812_rx_decoder_pin_sync_edge.sv
// Two-flop synchronizer for the serial line, followed by a previous-value
// register that yields single-cycle rise/fall strobes.
module pin_sync_edge
   import ws2812_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin_async,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = pin_async;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign level = sync2_q;
   assign rise  = sync2_q & ~prev_q;
   assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: classifies high pulses by width, assembles GRB pixels
// and detects the low latch gap that ends a frame.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_LOW  | line low; count gap length, close frame on a reset gap
//   ST_HIGH | line high; measure pulse width
//   ST_ERR  | after a width violation; wait for a clean reset gap
module ws2812_rx_decoder
   import ws2812_pkg::*;
#(
   parameter int HIGH_MIN     = 4,
   parameter int BIT_THRESH   = 15,
   parameter int HIGH_MAX     = 30,
   parameter int RESET_CYCLES = ws2812_pkg::RESET_CYCLES,
   parameter int CNT_W        = 11,
   parameter int IDX_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               led_stripe_pin,
   output logic [23:0]        pixel_data,
   output logic               pixel_valid,
   output logic [IDX_W-1:0]   pixel_index,
   output logic               frame_end,
   output logic               bit_error,
   output logic               rx_busy
);

   localparam logic [CNT_W-1:0] RESET_C    = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] HIGH_MIN_C = CNT_W'(HIGH_MIN);
   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(HIGH_MAX);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [4:0]       LAST_BIT   = 5'(PIXEL_W - 1);

   logic level, rise, fall;

   pin_sync_edge u_sync (
      .clk       (clk),
      .rst       (rst),
      .pin_async (led_stripe_pin),
      .level     (level),
      .rise      (rise),
      .fall      (fall)
   );

   logic [1:0]         state_q,       state_d;
   logic [CNT_W-1:0]   low_cnt_q,     low_cnt_d;
   logic [CNT_W-1:0]   high_cnt_q,    high_cnt_d;
   logic [4:0]         bit_cnt_q,     bit_cnt_d;
   logic [PIXEL_W-2:0] shift_q,       shift_d;
   pixel_t             pixel_data_q,  pixel_data_d;
   logic               pixel_valid_q, pixel_valid_d;
   logic [IDX_W-1:0]   pixel_index_q, pixel_index_d;
   logic [IDX_W-1:0]   pix_cnt_q,     pix_cnt_d;
   logic               frame_end_q,   frame_end_d;
   logic               bit_error_q,   bit_error_d;
   logic               rx_busy_q,     rx_busy_d;
   logic               bit_val;

   always_comb begin
      state_d       = state_q;
      low_cnt_d     = low_cnt_q;
      high_cnt_d    = high_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      pixel_data_d  = pixel_data_q;
      pixel_index_d = pixel_index_q;
      pix_cnt_d     = pix_cnt_q;
      rx_busy_d     = rx_busy_q;
      pixel_valid_d = 1'b0;
      frame_end_d   = 1'b0;
      bit_error_d   = 1'b0;
      bit_val       = (high_cnt_q >= THRESH_C);

      case (state_q)
         ST_LOW: begin
            if (low_cnt_q < RESET_C) begin
               low_cnt_d = low_cnt_q + ONE_C;
            end else if (rx_busy_q) begin
               // a partial pixel at the latch gap is dropped and flagged
               frame_end_d   = 1'b1;
               bit_error_d   = (bit_cnt_q != 5'd0);
               rx_busy_d     = 1'b0;
               bit_cnt_d     = 5'd0;
               pixel_index_d = '0;
               pix_cnt_d     = '0;
            end
            if (rise) begin
               state_d    = ST_HIGH;
               high_cnt_d = ONE_C;
            end
         end

         ST_HIGH: begin
            if (fall) begin
               if (high_cnt_q < HIGH_MIN_C) begin
                  bit_error_d = 1'b1;
                  state_d     = ST_ERR;
                  low_cnt_d   = '0;
                  bit_cnt_d   = 5'd0;
               end else begin
                  shift_d   = {shift_q[PIXEL_W-3:0], bit_val};
                  rx_busy_d = 1'b1;
                  state_d   = ST_LOW;
                  low_cnt_d = ONE_C;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d     = 5'd0;
                     pixel_data_d  = {shift_q, bit_val};
                     pixel_valid_d = 1'b1;
                     pixel_index_d = pix_cnt_q;
                     pix_cnt_d     = pix_cnt_q + 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else if (high_cnt_q >= HIGH_MAX_C) begin
               bit_error_d = 1'b1;
               state_d     = ST_ERR;
               low_cnt_d   = '0;
               bit_cnt_d   = 5'd0;
            end else begin
               high_cnt_d = high_cnt_q + ONE_C;
            end
         end

         ST_ERR: begin
            bit_cnt_d = 5'd0;
            if (level) begin
               low_cnt_d = '0;
            end else if (low_cnt_q >= RESET_C) begin
               state_d       = ST_LOW;
               rx_busy_d     = 1'b0;
               pixel_index_d = '0;
               pix_cnt_d     = '0;
            end else begin
               low_cnt_d = low_cnt_q + ONE_C;
            end
         end

         default: state_d = ST_LOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_LOW;
         low_cnt_q     <= '0;
         high_cnt_q    <= '0;
         bit_cnt_q     <= 5'd0;
         shift_q       <= '0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
         pixel_index_q <= '0;
         pix_cnt_q     <= '0;
         frame_end_q   <= 1'b0;
         bit_error_q   <= 1'b0;
         rx_busy_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         low_cnt_q     <= low_cnt_d;
         high_cnt_q    <= high_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_index_q <= pixel_index_d;
         pix_cnt_q     <= pix_cnt_d;
         frame_end_q   <= frame_end_d;
         bit_error_q   <= bit_error_d;
         rx_busy_q     <= rx_busy_d;
      end
   end

   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign pixel_index = pixel_index_q;
   assign frame_end   = frame_end_q;
   assign bit_error   = bit_error_q;
   assign rx_busy     = rx_busy_q;

endmodule
